// File: rtl/seq_prio_arbiter_pkg.sv
// Shared types for the sequential priority arbiter.
// The optional round-robin search is enabled with the RR_PRIORITY_EN macro.
package seq_prio_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/seq_prio_arbiter_prio_find.sv
// Combinational descending search with wrap: the first set request at or below `start` wins.
// When RR_PRIORITY_EN is undefined, the top ties `start` to N-1, which gives plain fixed priority.
module prio_find #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the farthest candidate to the nearest so the nearest hit is written last.
  always_comb begin
    logic [W-1:0] pos_s;
    int           p_s;
    found = 1'b0;
    idx   = '0;
    pos_s = '0;
    p_s   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      p_s = int'(start) - k;
      if (p_s < 0) begin
        p_s = p_s + N;
      end else begin
        p_s = p_s;
      end
      pos_s = W'(p_s);
      if (req[pos_s]) begin
        found = 1'b1;
        idx   = pos_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/seq_prio_arbiter.sv
// Registered N-way arbiter with a valid/ack grant handshake.
// Define RR_PRIORITY_EN for round-robin search; otherwise the highest set index always wins.
module seq_prio_arbiter
  import seq_prio_arbiter_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         gnt_ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  localparam logic [W-1:0] TOP_IDX = W'(N - 1);
  localparam logic [N-1:0] ONE_HOT = N'(1);

  arb_state_e   state_q, state_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic [W-1:0] start_s;
  logic         found_s;
  logic [W-1:0] win_s;
  logic         load_s;

`ifdef RR_PRIORITY_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] after_s;

  // On an ack edge the new winner is searched from the already-advanced pointer.
  always_comb begin
    after_s = (idx_q == '0) ? TOP_IDX : (idx_q - W'(1));
    if (state_q == ST_GRANT) begin
      start_s = after_s;
    end else begin
      start_s = ptr_q;
    end
  end
`else
  // Fixed priority: always search down from the highest index.
  always_comb begin
    start_s = TOP_IDX;
  end
`endif

  prio_find #(.N(N)) u_find (
    .req   (req),
    .start (start_s),
    .found (found_s),
    .idx   (win_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    load_s   = 1'b0;
`ifdef RR_PRIORITY_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          load_s  = 1'b1;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (gnt_ack) begin
`ifdef RR_PRIORITY_EN
          ptr_d = after_s;
`endif
          if (found_s) begin
            load_s  = 1'b1;
            state_d = ST_GRANT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // gnt_idx keeps its last value when the grant is dropped.
    if (load_s) begin
      valid_d  = 1'b1;
      idx_d    = win_s;
      onehot_d = ONE_HOT << win_s;
    end else if (state_d == ST_IDLE) begin
      valid_d  = 1'b0;
      onehot_d = '0;
    end else begin
      valid_d  = valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
`ifdef RR_PRIORITY_EN
      ptr_q    <= TOP_IDX;
`endif
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
`ifdef RR_PRIORITY_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign gnt_valid  = valid_q;
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;

endmodule
